ibex_pmp_csr_ctrl: RTL and testbench

CSR-side owner of the PMP state: holds the pmpcfg, pmpaddr and mseccfg registers, applies the lock, WARL and Smepmp write rules, and drives the configuration consumed by the PMP access checker. Sits between the CSR decode/request path and the PMP checker. Requests complete over a one-cycle request/ack handshake with registered read data.

---
 rtl/ibex_pmp_csr_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ibex_pmp_csr_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_pmp_csr_ctrl.sv
// PMP CSR owner: pmpcfg/pmpaddr/mseccfg storage with lock, WARL and Smepmp write rules,
// a one-cycle request/ack CSR port, and registered configuration for the PMP checker.

package ibex_pmp_csr_ctrl_pkg;

  typedef struct packed {
    logic       lock;
    logic [1:0] mode;
    logic       exec;
    logic       write;
    logic       read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  localparam logic [1:0] PMP_MODE_OFF   = 2'b00;
  localparam logic [1:0] PMP_MODE_TOR   = 2'b01;
  localparam logic [1:0] PMP_MODE_NA4   = 2'b10;
  localparam logic [1:0] PMP_MODE_NAPOT = 2'b11;

endpackage

module ibex_pmp_csr_ctrl
  import ibex_pmp_csr_ctrl_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               csr_req_i,
  input  logic               csr_we_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [31:0]        csr_wdata_i,
  output logic               csr_ack_o,
  output logic [31:0]        csr_rdata_o,
  output logic               csr_err_o,
  output pmp_cfg_t           csr_pmp_cfg_o     [PMPNumRegions],
  output logic [33:0]        csr_pmp_addr_o    [PMPNumRegions],
  output pmp_mseccfg_t       csr_pmp_mseccfg_o
);

  localparam int unsigned AddrW = 32;

  function automatic logic [AddrW-1:0] low_mask(int unsigned n);
    logic [AddrW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < AddrW; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [AddrW-1:0] OffMask   = low_mask(PMPGranularity);
  localparam logic [AddrW-1:0] NapotMask =
      low_mask((PMPGranularity >= 2) ? (PMPGranularity - 1) : 0);

  pmp_cfg_t         cfg_q   [PMPNumRegions];
  pmp_cfg_t         cfg_d   [PMPNumRegions];
  logic [AddrW-1:0] addr_q  [PMPNumRegions];
  logic [AddrW-1:0] addr_d  [PMPNumRegions];
  pmp_mseccfg_t     msec_q, msec_d;
  logic             ack_q, err_q;
  logic [31:0]      rdata_q;

  logic             is_cfg, is_addr, is_msec, is_msech;
  logic             hit_c;
  logic [31:0]      rdata_c;
  logic             any_lock;
  logic [PMPNumRegions:0]   tor_lock;
  logic [PMPNumRegions-1:0] addr_locked;
  logic             wr_en;

  function automatic logic [7:0] cfg_to_byte(pmp_cfg_t c);
    return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
  endfunction

  // One cfg byte against the state at the start of the cycle; a rejected byte keeps its value.
  function automatic pmp_cfg_t cfg_wr(pmp_cfg_t old, logic [7:0] b, logic rlb, logic mml);
    pmp_cfg_t   n;
    logic [2:0] rwx;
    n   = {b[7], b[4:3], b[2], b[1], b[0]};
    rwx = {b[0], b[1], b[2]};
    if (old.lock && !rlb) return old;
    if (!mml && !b[0] && b[1]) return old;
    if (mml && !rlb && b[7] &&
        (rwx == 3'b001 || rwx == 3'b101 || rwx == 3'b010 || rwx == 3'b011)) return old;
    if (PMPGranularity != 0 && n.mode == PMP_MODE_NA4) n.mode = PMP_MODE_OFF;
    return n;
  endfunction

  function automatic logic [AddrW-1:0] addr_rd(logic [AddrW-1:0] a, logic [1:0] mode);
    if (PMPGranularity == 0) return a;
    if (mode == PMP_MODE_NAPOT) return a | NapotMask;
    if (!mode[1]) return a & ~OffMask;
    return a;
  endfunction

  assign is_cfg   = (csr_addr_i[11:2] == 10'h0E8);
  assign is_addr  = (csr_addr_i[11:4] == 8'h3B);
  assign is_msec  = (csr_addr_i == 12'h747);
  assign is_msech = (csr_addr_i == 12'h757);
  assign hit_c    = is_cfg | is_addr | is_msec | is_msech;
  assign wr_en    = csr_req_i & csr_we_i;

  // Lock summary: any locked region, and locked TOR regions that also protect the address below.
  always_comb begin
    any_lock    = 1'b0;
    tor_lock    = '0;
    addr_locked = '0;
    for (int unsigned r = 0; r < PMPNumRegions; r++) begin
      any_lock    = any_lock | cfg_q[r].lock;
      tor_lock[r] = cfg_q[r].lock && (cfg_q[r].mode == PMP_MODE_TOR);
    end
    for (int unsigned r = 0; r < PMPNumRegions; r++) begin
      addr_locked[r] = !msec_q.rlb && (cfg_q[r].lock || tor_lock[r+1]);
    end
  end

  // Read mux returns the pre-write value of the addressed CSR.
  always_comb begin
    rdata_c = '0;
    if (is_cfg) begin
      for (int unsigned r = 0; r < PMPNumRegions; r++) begin
        if (csr_addr_i[1:0] == 2'(r / 4)) rdata_c[8*(r%4) +: 8] = cfg_to_byte(cfg_q[r]);
      end
    end else if (is_addr) begin
      for (int unsigned r = 0; r < PMPNumRegions; r++) begin
        if (csr_addr_i[3:0] == 4'(r)) rdata_c = addr_rd(addr_q[r], cfg_q[r].mode);
      end
    end else if (is_msec) begin
      rdata_c = {29'b0, msec_q.rlb, msec_q.mmwp, msec_q.mml};
    end
  end

  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    msec_d = msec_q;
    if (wr_en && is_cfg) begin
      for (int unsigned r = 0; r < PMPNumRegions; r++) begin
        if (csr_addr_i[1:0] == 2'(r / 4)) begin
          cfg_d[r] = cfg_wr(cfg_q[r], csr_wdata_i[8*(r%4) +: 8], msec_q.rlb, msec_q.mml);
        end
      end
    end
    if (wr_en && is_addr) begin
      for (int unsigned r = 0; r < PMPNumRegions; r++) begin
        if (csr_addr_i[3:0] == 4'(r) && !addr_locked[r]) addr_d[r] = csr_wdata_i;
      end
    end
    // mml/mmwp are sticky; rlb only moves while unlocked or already set.
    if (wr_en && is_msec) begin
      msec_d.mml  = msec_q.mml  | csr_wdata_i[0];
      msec_d.mmwp = msec_q.mmwp | csr_wdata_i[1];
      if (msec_q.rlb || !any_lock) msec_d.rlb = csr_wdata_i[2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q   <= '{default: '0};
      addr_q  <= '{default: '0};
      msec_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      msec_q  <= msec_d;
      ack_q   <= csr_req_i;
      err_q   <= csr_req_i & ~hit_c;
      rdata_q <= csr_req_i ? rdata_c : 32'h0;
    end
  end

  assign csr_ack_o         = ack_q;
  assign csr_err_o         = err_q;
  assign csr_rdata_o       = rdata_q;
  assign csr_pmp_cfg_o     = cfg_q;
  assign csr_pmp_mseccfg_o = msec_q;

  for (genvar g = 0; g < PMPNumRegions; g++) begin : g_addr_out
    assign csr_pmp_addr_o[g] = {addr_q[g], 2'b00};
  end

endmodule

// File: tb/tb_ibex_pmp_csr_ctrl.sv
// Directed bench for ibex_pmp_csr_ctrl: table of CSR requests with expected read-back,
// plus hand sequences for output timing, back-to-back access and reset during a request.

module tb_ibex_pmp_csr_ctrl;
  import ibex_pmp_csr_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_g0, req_g2, csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;

  logic         ack0, err0, ack2, err2;
  logic [31:0]  rdata0, rdata2;
  pmp_cfg_t     cfg0 [4];
  pmp_cfg_t     cfg2 [4];
  logic [33:0]  addr0 [4];
  logic [33:0]  addr2 [4];
  pmp_mseccfg_t msec0, msec2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibex_pmp_csr_ctrl #(.PMPGranularity(0), .PMPNumRegions(4)) u_dut_g0 (
    .clk_i(clk), .rst_i(rst), .csr_req_i(req_g0), .csr_we_i(csr_we),
    .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
    .csr_ack_o(ack0), .csr_rdata_o(rdata0), .csr_err_o(err0),
    .csr_pmp_cfg_o(cfg0), .csr_pmp_addr_o(addr0), .csr_pmp_mseccfg_o(msec0)
  );

  ibex_pmp_csr_ctrl #(.PMPGranularity(2), .PMPNumRegions(4)) u_dut_g2 (
    .clk_i(clk), .rst_i(rst), .csr_req_i(req_g2), .csr_we_i(csr_we),
    .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
    .csr_ack_o(ack2), .csr_rdata_o(rdata2), .csr_err_o(err2),
    .csr_pmp_cfg_o(cfg2), .csr_pmp_addr_o(addr2), .csr_pmp_mseccfg_o(msec2)
  );

  typedef struct {
    bit          rst;
    bit          g2;
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_req(bit g2, bit we, logic [11:0] a, logic [31:0] d,
                                  logic [31:0] er, bit ee);
    vec_t v;
    v = '{rst: 1'b0, g2: g2, we: we, addr: a, wdata: d, exp_rdata: er, exp_err: ee};
    vecs.push_back(v);
  endfunction

  function automatic void add_rst();
    vec_t v;
    v = '{rst: 1'b1, g2: 1'b0, we: 1'b0, addr: 12'h0, wdata: 32'h0, exp_rdata: 32'h0, exp_err: 1'b0};
    vecs.push_back(v);
  endfunction

  function automatic void wr(bit g2, logic [11:0] a, logic [31:0] d, logic [31:0] er);
    add_req(g2, 1'b1, a, d, er, 1'b0);
  endfunction

  function automatic void rd(bit g2, logic [11:0] a, logic [31:0] er);
    add_req(g2, 1'b0, a, 32'h0, er, 1'b0);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(bit g2, bit we, logic [11:0] a, logic [31:0] d);
    @(negedge clk);
    req_g0    = !g2;
    req_g2    = g2;
    csr_we    = we;
    csr_addr  = a;
    csr_wdata = d;
  endtask

  task automatic sample(bit g2, output logic ack, output logic [31:0] rdat, output logic err);
    @(posedge clk);
    #1;
    ack  = g2 ? ack2 : ack0;
    rdat = g2 ? rdata2 : rdata0;
    err  = g2 ? err2 : err0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_g0 = 1'b0;
    req_g2 = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        a_s, e_s;
    logic [31:0] r_s;

    rst = 1'b1; req_g0 = 1'b0; req_g2 = 1'b0;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;

    // Basic access, lock on TOR neighbour, rlb blocked, unmapped and unimplemented CSRs
    add_rst();
    rd(0, 12'h3A0, 32'h0);
    rd(0, 12'h3B0, 32'h0);
    wr(0, 12'h3A0, 32'h0000_001F, 32'h0);
    rd(0, 12'h3A0, 32'h0000_001F);
    wr(0, 12'h3B0, 32'h0000_1000, 32'h0);
    wr(0, 12'h3A0, 32'h0000_8F00, 32'h0000_001F);
    rd(0, 12'h3A0, 32'h0000_8F00);
    wr(0, 12'h3B0, 32'h0000_2000, 32'h0000_1000);
    rd(0, 12'h3B0, 32'h0000_1000);
    wr(0, 12'h3B1, 32'h0000_0005, 32'h0);
    rd(0, 12'h3B1, 32'h0);
    wr(0, 12'h747, 32'h0000_0004, 32'h0);
    rd(0, 12'h747, 32'h0);
    wr(0, 12'h3A0, 32'h0000_0000, 32'h0000_8F00);
    rd(0, 12'h3A0, 32'h0000_8F00);
    wr(0, 12'h3B3, 32'h0000_ABCD, 32'h0);
    rd(0, 12'h3B3, 32'h0000_ABCD);
    wr(0, 12'h3A1, 32'hFFFF_FFFF, 32'h0);
    rd(0, 12'h3A1, 32'h0);
    rd(0, 12'h3B4, 32'h0);
    wr(0, 12'h757, 32'hFFFF_FFFF, 32'h0);
    rd(0, 12'h757, 32'h0);
    add_req(0, 1'b0, 12'h300, 32'h0, 32'h0, 1'b1);
    add_req(0, 1'b0, 12'h3A4, 32'h0, 32'h0, 1'b1);
    add_req(0, 1'b1, 12'h300, 32'h1234, 32'h0, 1'b1);
    rd(0, 12'h3A0, 32'h0000_8F00);

    // Rule-locking bypass
    add_rst();
    wr(0, 12'h747, 32'h4, 32'h0);
    rd(0, 12'h747, 32'h4);
    wr(0, 12'h3A0, 32'h9F, 32'h0);
    rd(0, 12'h3A0, 32'h9F);
    wr(0, 12'h3B0, 32'h77, 32'h0);
    rd(0, 12'h3B0, 32'h77);
    wr(0, 12'h3A0, 32'h00, 32'h9F);
    rd(0, 12'h3A0, 32'h00);
    wr(0, 12'h3A0, 32'h9F, 32'h00);
    wr(0, 12'h747, 32'h0, 32'h4);
    rd(0, 12'h747, 32'h0);
    wr(0, 12'h747, 32'h4, 32'h0);
    rd(0, 12'h747, 32'h0);
    wr(0, 12'h3A0, 32'h00, 32'h9F);
    rd(0, 12'h3A0, 32'h9F);

    // Machine-mode lockdown rules and sticky bits
    add_rst();
    wr(0, 12'h3A0, 32'h02, 32'h0);
    rd(0, 12'h3A0, 32'h0);
    wr(0, 12'h747, 32'h1, 32'h0);
    rd(0, 12'h747, 32'h1);
    wr(0, 12'h3A0, 32'h02, 32'h0);
    rd(0, 12'h3A0, 32'h02);
    wr(0, 12'h3A0, 32'h9D, 32'h02);
    rd(0, 12'h3A0, 32'h02);
    wr(0, 12'h3A0, 32'h87, 32'h02);
    rd(0, 12'h3A0, 32'h87);
    wr(0, 12'h3A0, 32'h0000_0487, 32'h87);
    rd(0, 12'h3A0, 32'h0000_0487);
    wr(0, 12'h747, 32'h0, 32'h1);
    rd(0, 12'h747, 32'h1);
    wr(0, 12'h747, 32'h2, 32'h1);
    rd(0, 12'h747, 32'h3);

    // Per-byte independence and TOR-only neighbour protection
    add_rst();
    wr(0, 12'h3A0, 32'h0000_0280, 32'h0);
    rd(0, 12'h3A0, 32'h0000_0080);
    wr(0, 12'h3A0, 32'h0000_0380, 32'h0000_0080);
    rd(0, 12'h3A0, 32'h0000_0380);
    wr(0, 12'h3B0, 32'h1, 32'h0);
    rd(0, 12'h3B0, 32'h0);
    wr(0, 12'h3A0, 32'h0098_0380, 32'h0000_0380);
    wr(0, 12'h3B1, 32'h55, 32'h0);
    rd(0, 12'h3B1, 32'h55);

    // Granularity 2: NA4 squashed, pmpaddr read-back shaping
    wr(1, 12'h3A0, 32'h10, 32'h0);
    rd(1, 12'h3A0, 32'h00);
    wr(1, 12'h3A0, 32'h18, 32'h0);
    rd(1, 12'h3B0, 32'h1);
    wr(1, 12'h3A0, 32'h08, 32'h18);
    rd(1, 12'h3B0, 32'h0);
    wr(1, 12'h3B0, 32'hF6, 32'h0);
    rd(1, 12'h3B0, 32'hF4);
    wr(1, 12'h3A0, 32'h18, 32'h08);
    rd(1, 12'h3B0, 32'hF7);
    wr(1, 12'h3A0, 32'h13, 32'h18);
    rd(1, 12'h3A0, 32'h03);
    rd(1, 12'h3B0, 32'hF4);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", 64'(ack0), 64'(1'b0));
    check("reset_rdata_err", 64'({err0, rdata0}), 64'h0);
    check("reset_cfg_addr", 64'({cfg0[0], cfg0[3], addr0[0], addr0[3] != 34'h0}), 64'h0);
    check("reset_mseccfg", 64'(msec0), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
      end else begin
        drive(vecs[i].g2, vecs[i].we, vecs[i].addr, vecs[i].wdata);
        sample(vecs[i].g2, a_s, r_s, e_s);
        check($sformatf("vec%0d_addr%03h", i, vecs[i].addr), 64'({a_s, e_s, r_s}),
              64'({1'b1, vecs[i].exp_err, vecs[i].exp_rdata}));
      end
    end

    // Checker outputs update in the ack cycle; back-to-back write then read
    do_reset();
    drive(0, 1'b1, 12'h3A0, 32'h0000_8F00);
    sample(0, a_s, r_s, e_s);
    check("cfg_out_region1", 64'(cfg0[1]), 64'(6'b1_01_111));
    check("cfg_out_region0", 64'(cfg0[0]), 64'h0);
    drive(0, 1'b1, 12'h747, 32'h3);
    sample(0, a_s, r_s, e_s);
    check("mseccfg_out", 64'(msec0), 64'(3'b011));
    drive(0, 1'b1, 12'h3B2, 32'h1234_5678);
    sample(0, a_s, r_s, e_s);
    check("b2b_wr_ack", 64'(a_s), 64'h1);
    check("addr_out_region2", 64'(addr0[2]), 64'h0_48D1_59E0);
    drive(0, 1'b0, 12'h3B2, 32'h0);
    sample(0, a_s, r_s, e_s);
    check("b2b_rd", 64'({a_s, r_s}), 64'({1'b1, 32'h1234_5678}));

    // Reset asserted together with a request: dropped, state cleared
    drive(0, 1'b0, 12'h3A0, 32'h0);
    rst = 1'b1;
    sample(0, a_s, r_s, e_s);
    check("rst_req_no_ack", 64'(a_s), 64'h0);
    check("rst_clears_state", 64'({cfg0[1], msec0, addr0[2] != 34'h0}), 64'h0);
    @(negedge clk);
    rst    = 1'b0;
    req_g0 = 1'b0;
    sample(0, a_s, r_s, e_s);
    check("idle_no_ack", 64'({a_s, e_s, r_s}), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
